ej32_fetch: RTL and testbench
=============================

Name: ej32_fetch

Overview:
- Bytecode fetch and instruction-assembly stage that sits directly upstream of the eJ32 decoder/execution core.
- Reads the instruction byte stream from byte-wide program memory through a small prefetch FIFO.
- Classifies each opcode by operand length and packs the operand bytes, big-endian, into one word.
- Hands complete instructions (opcode, operand, length, pc) to the core over a valid/ready handshake; a jump input flushes and redirects the stream.

Parameters:
- ASZ, 17, instruction address width.
- DSZ, 32, data/operand width.
- QD, 4, prefetch FIFO depth in bytes; power of 2, at least 2.
- RST_PC, 0, fetch address after reset.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- jmp_v  in  1  redirect request, sampled at the clock edge.
- jmp_a  in  ASZ  redirect target address.
- mem_en  out  1  memory read strobe.
- mem_a  out  ASZ  memory read address.
- mem_d  in  8  read data, valid one cycle after the strobe.
- out_v  out  1  instruction valid.
- out_rdy  in  1  consumer ready.
- out_op  out  8  opcode (opcode_t).
- out_arg  out  DSZ  operand bytes, zero-extended.
- out_len  out  3  total instruction bytes, 1..5.
- out_pc  out  ASZ  address of the opcode byte.
- out_err  out  1  opcode unsupported by fetch.

Behaviour:
- Reset values: mem_en=0, mem_a=RST_PC, out_v=0, out_op=nop, out_arg=0, out_len=1, out_pc=RST_PC, out_err=0. FIFO is empty, no read is in flight, assembler is in S_OP.
- Reset asserted mid-operation: same result as power-on reset; any in-flight byte is discarded.
- Fetcher:
  - Issues mem_en=1 when count + inflight < QD; inflight is 0 or 1.
  - mem_a increments after each issue and wraps modulo 2^ASZ.
  - A returned byte is written to the FIFO at the end of the cycle after its strobe.
  - First cycle after reset: strobe at RST_PC.
- Operand-byte table (n), a function of opcode only:
  - n=1: bipush, ldc, iload..aload, istore..astore, ret, newarray.
  - n=2: sipush, ldc_w, ldc2_w, iinc, ifeq..jsr, getstatic..invokestatic, jnew, anewarray, checkcast, instanceof, ifnull, ifnotnull, donext.
  - n=3: multianewarray.
  - n=4: invokeinterface, invokedynamic, goto_w, jsr_w, ldi.
  - n=0: all other opcodes.
  - tableswitch, lookupswitch, wide, op_err: n=0 and out_err=1.
- Assembler FSM:
  - S_OP: when the FIFO is non-empty, pop the opcode byte, latch out_op, latch out_pc (address of that byte), clear arg, set k=n. Go to S_OUT if n=0, else S_ARG.
  - S_ARG: each cycle the FIFO is non-empty, pop a byte, arg={arg[DSZ-9:0], byte}, k=k-1. Go to S_OUT after the last byte. Cycles with the FIFO empty stall in place.
  - S_OUT: out_v=1 and out_* held stable until out_rdy=1.
    - On handshake with the FIFO non-empty: the next opcode is popped in the same cycle (S_OP action).
    - On handshake with the FIFO empty: go to S_OP.
- Latency: the first out_v after reset for a 1-byte opcode is at cycle 3 (strobe at 0, write at 1, pop at 2). Sustained rate with out_rdy=1 is one byte per cycle.
- Redirect (jmp_v=1 at an edge):
  - Next cycle: FIFO empty, in-flight byte discarded (not written), FSM in S_OP, out_v=0, mem_en=1 with mem_a=jmp_a.
  - If out_v and out_rdy are both 1 in the same cycle as jmp_v, the handshake counts as completed.
- jmp_v together with rst: rst wins.
- out_v never depends combinationally on out_rdy.

Decomposition:
- Shared package ej32_pkg: opcode_t, DSZ/ASZ, and a new function opc_nargs(opcode_t) returning a 3-bit n plus the error flag. The decoder and the fetcher use the same table.
- One sub-module: ej32_fifo, a byte FIFO with parameter QD, push/pop/flush, and count output, all synchronous.

Test Plan:
- Reset with memory holding nop, iconst_1, iadd → mem_a=0 at cycle 0, out_v at cycle 3 with out_op=0x00, out_pc=0. Then 0x04 and 0x60 on consecutive cycles with out_len=1.
- bipush 0x7f at 0x10 → out_op=0x10, out_arg=0x0000007f, out_len=2, out_pc=0x10.
- ldi 12 34 56 78 → out_op=0xcb, out_arg=0x12345678, out_len=5; next opcode's out_pc = previous out_pc + 5.
- out_rdy=0 for 10 cycles during a stream → out_* stable, at most QD bytes buffered plus one in flight, mem_en stops, no byte lost or duplicated after release.
- goto at 0x20 then jmp_v=1, jmp_a=0x100 while a read is in flight → next cycle mem_a=0x100, stale bytes never appear, first output has out_pc=0x100.
- tableswitch → out_err=1, out_len=1. Separately, rst during S_ARG of sipush → outputs at reset values, refetch from RST_PC.

Source files
------------

// File: rtl/ej32_pkg.sv
// Shared eJ32 definitions: opcode encoding and the operand-length table used by fetch and decode.
package ej32_pkg;

  localparam int unsigned ASZ = 17;
  localparam int unsigned DSZ = 32;

  typedef enum logic [7:0] {
    nop             = 8'h00,
    iconst_1        = 8'h04,
    bipush          = 8'h10,
    sipush          = 8'h11,
    ldc             = 8'h12,
    ldc_w           = 8'h13,
    ldc2_w          = 8'h14,
    iload           = 8'h15,
    aload           = 8'h19,
    istore          = 8'h36,
    astore          = 8'h3a,
    iadd            = 8'h60,
    iinc            = 8'h84,
    ifeq            = 8'h99,
    jsr             = 8'ha8,
    ret             = 8'ha9,
    tableswitch     = 8'haa,
    lookupswitch    = 8'hab,
    getstatic       = 8'hb2,
    invokestatic    = 8'hb8,
    invokeinterface = 8'hb9,
    invokedynamic   = 8'hba,
    jnew            = 8'hbb,
    newarray        = 8'hbc,
    anewarray       = 8'hbd,
    checkcast       = 8'hc0,
    instanceof      = 8'hc1,
    wide            = 8'hc4,
    multianewarray  = 8'hc5,
    ifnull          = 8'hc6,
    ifnonnull       = 8'hc7,
    goto_w          = 8'hc8,
    jsr_w           = 8'hc9,
    donext          = 8'hca,
    ldi             = 8'hcb,
    op_err          = 8'hff
  } opcode_t;

  typedef struct packed {
    logic       err;
    logic [2:0] n;
  } nargs_t;

  // Operand byte count depends on the opcode alone; variable-length forms are flagged.
  function automatic nargs_t opc_nargs(opcode_t op);
    nargs_t r;
    r.err = 1'b0;
    r.n   = 3'd0;
    case (op) inside
      bipush, ldc, [iload:aload], [istore:astore], ret, newarray: r.n = 3'd1;
      sipush, ldc_w, ldc2_w, iinc, [ifeq:jsr], [getstatic:invokestatic], jnew, anewarray,
      checkcast, instanceof, ifnull, ifnonnull, donext: r.n = 3'd2;
      multianewarray: r.n = 3'd3;
      invokeinterface, invokedynamic, goto_w, jsr_w, ldi: r.n = 3'd4;
      tableswitch, lookupswitch, wide, op_err: r.err = 1'b1;
      default: r.n = 3'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ej32_fifo.sv
// Byte-wide prefetch FIFO with synchronous reset and flush; flush overrides push and pop.
module ej32_fifo #(
  parameter int unsigned QD = 4,
  localparam int unsigned AW = $clog2(QD),
  localparam int unsigned CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic [7:0]    din,
  input  logic          pop,
  output logic [7:0]    dout,
  output logic [CW-1:0] count,
  output logic          empty
);

  logic [7:0]    mem [QD];
  logic [AW-1:0] wp_q, rp_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  always_comb begin
    do_push = push & (cnt_q != CW'(QD));
    do_pop  = pop & (cnt_q != '0);
    dout    = mem[rp_q];
    count   = cnt_q;
    empty   = (cnt_q == '0);
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wp_q <= wp_q + AW'(1);
      if (do_pop)  rp_q <= rp_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush && !rst) mem[wp_q] <= din;
  end

endmodule

// File: rtl/ej32_fetch.sv
// eJ32 bytecode fetch: prefetches program bytes into a small FIFO and assembles opcode+operand
// instructions for the core over a valid/ready handshake; jmp_v flushes and redirects.
module ej32_fetch
  import ej32_pkg::opcode_t;
  import ej32_pkg::nargs_t;
  import ej32_pkg::opc_nargs;
  import ej32_pkg::nop;
#(
  parameter int unsigned    ASZ    = ej32_pkg::ASZ,
  parameter int unsigned    DSZ    = ej32_pkg::DSZ,
  parameter int unsigned    QD     = 4,
  parameter logic [ASZ-1:0] RST_PC = '0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           jmp_v,
  input  logic [ASZ-1:0] jmp_a,
  output logic           mem_en,
  output logic [ASZ-1:0] mem_a,
  input  logic [7:0]     mem_d,
  output logic           out_v,
  input  logic           out_rdy,
  output opcode_t        out_op,
  output logic [DSZ-1:0] out_arg,
  output logic [2:0]     out_len,
  output logic [ASZ-1:0] out_pc,
  output logic           out_err
);

  localparam int unsigned CW = $clog2(QD) + 1;

  typedef enum logic [1:0] {StOp, StArg, StOut} state_e;

  state_e         state_q, state_d;
  logic [ASZ-1:0] fa_q, fa_d;
  logic [ASZ-1:0] rd_pc_q, rd_pc_d;
  logic           inflight_q, inflight_d;
  opcode_t        op_q, op_d;
  logic [DSZ-1:0] arg_q, arg_d;
  logic [2:0]     len_q, len_d;
  logic [2:0]     k_q, k_d;
  logic [ASZ-1:0] pc_q, pc_d;
  logic           err_q, err_d;

  logic           fifo_push, fifo_pop, fifo_flush, fifo_empty;
  logic [7:0]     fifo_dout;
  logic [CW-1:0]  fifo_cnt;
  logic [CW:0]    occ;
  logic           load_op;
  nargs_t         nargs;

  ej32_fifo #(
    .QD(QD)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (fifo_flush),
    .push  (fifo_push),
    .din   (mem_d),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .count (fifo_cnt),
    .empty (fifo_empty)
  );

  // Fetcher: keep buffered plus in-flight bytes within the FIFO depth.
  always_comb begin
    occ        = {1'b0, fifo_cnt} + (CW+1)'(inflight_q);
    mem_en     = ~rst & (occ < (CW+1)'(QD));
    fa_d       = mem_en ? fa_q + ASZ'(1) : fa_q;
    inflight_d = mem_en;
    fifo_push  = inflight_q & ~jmp_v;
    fifo_flush = jmp_v;
    if (jmp_v) begin
      fa_d       = jmp_a;
      inflight_d = 1'b0;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    arg_d    = arg_q;
    len_d    = len_q;
    k_d      = k_q;
    pc_d     = pc_q;
    err_d    = err_q;
    rd_pc_d  = rd_pc_q;
    fifo_pop = 1'b0;
    load_op  = 1'b0;
    nargs    = opc_nargs(opcode_t'(fifo_dout));

    if (jmp_v) begin
      // A handshake coinciding with the redirect is simply allowed to complete.
      state_d = StOp;
      rd_pc_d = jmp_a;
    end else begin
      case (state_q)
        StOp: load_op = ~fifo_empty;
        StArg: begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            arg_d    = {arg_q[DSZ-9:0], fifo_dout};
            k_d      = k_q - 3'd1;
            if (k_q == 3'd1) state_d = StOut;
          end
        end
        StOut: begin
          if (out_rdy) begin
            if (!fifo_empty) load_op = 1'b1;
            else             state_d = StOp;
          end
        end
        default: state_d = StOp;
      endcase

      if (load_op) begin
        fifo_pop = 1'b1;
        op_d     = opcode_t'(fifo_dout);
        pc_d     = rd_pc_q;
        arg_d    = '0;
        err_d    = nargs.err;
        k_d      = nargs.n;
        len_d    = nargs.n + 3'd1;
        state_d  = (nargs.n == 3'd0) ? StOut : StArg;
      end
      if (fifo_pop) rd_pc_d = rd_pc_q + ASZ'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StOp;
      fa_q       <= RST_PC;
      rd_pc_q    <= RST_PC;
      inflight_q <= 1'b0;
      op_q       <= nop;
      arg_q      <= '0;
      len_q      <= 3'd1;
      k_q        <= 3'd0;
      pc_q       <= RST_PC;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fa_q       <= fa_d;
      rd_pc_q    <= rd_pc_d;
      inflight_q <= inflight_d;
      op_q       <= op_d;
      arg_q      <= arg_d;
      len_q      <= len_d;
      k_q        <= k_d;
      pc_q       <= pc_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    mem_a   = fa_q;
    out_v   = (state_q == StOut);
    out_op  = op_q;
    out_arg = arg_q;
    out_len = len_q;
    out_pc  = pc_q;
    out_err = err_q;
  end

endmodule

// File: tb/tb_ej32_fetch.sv
// Bench for ej32_fetch: byte memory model, program-walking reference model, directed scenarios.
module tb_ej32_fetch;

  localparam int QD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        jmp_v = 1'b0;
  logic [16:0] jmp_a = '0;
  logic        mem_en;
  logic [16:0] mem_a;
  logic [7:0]  mem_d = '0;
  logic        out_v;
  logic        out_rdy = 1'b1;
  logic [7:0]  out_op;
  logic [31:0] out_arg;
  logic [2:0]  out_len;
  logic [16:0] out_pc;
  logic        out_err;

  logic [7:0]  mem [1024];
  int          n_chk = 0;
  int          n_fail = 0;

  ej32_fetch #(
    .ASZ(17), .DSZ(32), .QD(QD), .RST_PC(17'h0)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .jmp_v   (jmp_v),
    .jmp_a   (jmp_a),
    .mem_en  (mem_en),
    .mem_a   (mem_a),
    .mem_d   (mem_d),
    .out_v   (out_v),
    .out_rdy (out_rdy),
    .out_op  (out_op),
    .out_arg (out_arg),
    .out_len (out_len),
    .out_pc  (out_pc),
    .out_err (out_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_en) mem_d <= mem[mem_a[9:0]];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Operand bytes per opcode, straight from the instruction-length rules.
  function automatic void ref_nargs(input logic [7:0] op, output int n, output bit err);
    err = 0;
    n   = 0;
    if (op inside {8'haa, 8'hab, 8'hc4, 8'hff}) err = 1;
    else if (op inside {8'h10, 8'h12, [8'h15:8'h19], [8'h36:8'h3a], 8'ha9, 8'hbc}) n = 1;
    else if (op inside {8'h11, 8'h13, 8'h14, 8'h84, [8'h99:8'ha8], [8'hb2:8'hb8], 8'hbb, 8'hbd,
                        8'hc0, 8'hc1, 8'hc6, 8'hc7, 8'hca}) n = 2;
    else if (op == 8'hc5) n = 3;
    else if (op inside {8'hb9, 8'hba, 8'hc8, 8'hc9, 8'hcb}) n = 4;
  endfunction

  task automatic expect_at(input logic [16:0] pc, output logic [7:0] op, output logic [31:0] arg,
                           output int len, output bit err);
    int n;
    logic [16:0] a;
    op  = mem[pc[9:0]];
    ref_nargs(op, n, err);
    arg = '0;
    for (int i = 1; i <= n; i++) begin
      a   = pc + 17'(i);
      arg = {arg[23:0], mem[a[9:0]]};
    end
    len = n + 1;
  endtask

  // Reference model: every accepted instruction must be the next one in program order.
  initial begin : compare
    logic [16:0] exp_pc;
    logic [7:0]  e_op, p_op;
    logic [31:0] e_arg, p_arg;
    logic [2:0]  p_len;
    logic [16:0] p_pc;
    logic        p_err;
    int          e_len;
    bit          e_err, have_prev;
    exp_pc    = '0;
    have_prev = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_pc    = '0;
        have_prev = 0;
      end else begin
        if (have_prev) begin
          check("hold_v", 64'(out_v), 64'(1'b1));
          check("hold_fields", {out_op, out_arg, out_len, out_pc, out_err},
                {p_op, p_arg, p_len, p_pc, p_err});
        end
        if (out_v && out_rdy) begin
          expect_at(exp_pc, e_op, e_arg, e_len, e_err);
          check("model_pc", 64'(out_pc), 64'(exp_pc));
          check("model_op", 64'(out_op), 64'(e_op));
          check("model_arg", 64'(out_arg), 64'(e_arg));
          check("model_len", 64'(out_len), 64'(e_len));
          check("model_err", 64'(out_err), 64'(e_err));
          exp_pc = exp_pc + 17'(e_len);
        end
        have_prev = out_v && !out_rdy && !jmp_v;
        p_op  = out_op;
        p_arg = out_arg;
        p_len = out_len;
        p_pc  = out_pc;
        p_err = out_err;
        if (jmp_v) exp_pc = jmp_a;
      end
    end
  end

  task automatic wait_pc(input logic [16:0] pc, input string name);
    bit hit = 0;
    for (int i = 0; i < 60 && !hit; i++) begin
      @(negedge clk);
      if (out_v && out_pc == pc) hit = 1;
    end
    n_chk++;
    if (!hit) begin
      n_fail++;
      $display("FAIL %s: out_pc got none expected %0h within 60 cycles", name, pc);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_mem_en"}, 64'(mem_en), 64'(0));
    check({tag, "_mem_a"}, 64'(mem_a), 64'(0));
    check({tag, "_out_v"}, 64'(out_v), 64'(0));
    check({tag, "_out_fields"}, {out_op, out_arg, out_len, out_pc, out_err},
          {8'h00, 32'h0, 3'd1, 17'h0, 1'b0});
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation got stuck, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int strobes;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    mem[1] = 8'h04; mem[2] = 8'h60;
    mem[16'h10] = 8'h10; mem[16'h11] = 8'h7f;
    mem[16'h12] = 8'hcb; mem[16'h13] = 8'h12; mem[16'h14] = 8'h34;
    mem[16'h15] = 8'h56; mem[16'h16] = 8'h78;
    mem[16'h17] = 8'h11; mem[16'h18] = 8'hab; mem[16'h19] = 8'hcd;
    mem[16'h20] = 8'ha7; mem[16'h21] = 8'h00; mem[16'h22] = 8'h10;
    mem[16'h23] = 8'h10; mem[16'h24] = 8'h55;
    mem[16'h100] = 8'h60; mem[16'h101] = 8'haa;
    mem[16'h200] = 8'h11; mem[16'h201] = 8'haa; mem[16'h202] = 8'hbb;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_vals("por");

    // Startup latency: strobe in cycle 0, first instruction valid in cycle 3.
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("c0_mem_en", 64'(mem_en), 64'(1));
    check("c0_mem_a", 64'(mem_a), 64'(0));
    @(negedge clk);
    check("c1_mem_a", 64'(mem_a), 64'(1));
    @(negedge clk);
    check("c2_out_v", 64'(out_v), 64'(0));
    @(negedge clk);
    check("c3_out", {out_v, out_op, out_pc, out_len}, {1'b1, 8'h00, 17'h0, 3'd1});
    @(negedge clk);
    check("c4_out", {out_v, out_op, out_pc, out_len}, {1'b1, 8'h04, 17'h1, 3'd1});
    @(negedge clk);
    check("c5_out", {out_v, out_op, out_pc, out_len}, {1'b1, 8'h60, 17'h2, 3'd1});

    wait_pc(17'h10, "bipush_seen");
    check("bipush", {out_op, out_arg, out_len, out_err}, {8'h10, 32'h7f, 3'd2, 1'b0});
    wait_pc(17'h12, "ldi_seen");
    check("ldi", {out_op, out_arg, out_len, out_err}, {8'hcb, 32'h12345678, 3'd5, 1'b0});
    wait_pc(17'h17, "after_ldi_seen");
    check("sipush", {out_op, out_arg, out_len}, {8'h11, 32'h0000abcd, 3'd3});

    // Back-pressure: outputs hold (checked by the model), fetch stops once the FIFO fills.
    wait_pc(17'h1a, "stall_start");
    @(posedge clk); #1 out_rdy = 1'b0;
    strobes = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_en) strobes++;
    end
    check("stall_mem_en", 64'(mem_en), 64'(0));
    check("stall_out_v", 64'(out_v), 64'(1));
    n_chk++;
    if (strobes > QD + 1) begin
      n_fail++;
      $display("FAIL stall_strobes: got %0d expected at most %0d", strobes, QD + 1);
    end
    @(posedge clk); #1 out_rdy = 1'b1;

    wait_pc(17'h20, "goto_seen");
    check("goto", {out_op, out_arg, out_len}, {8'ha7, 32'h0010, 3'd3});
    @(posedge clk); #1 jmp_v = 1'b1; jmp_a = 17'h100;
    @(posedge clk); #1 jmp_v = 1'b0;
    @(negedge clk);
    check("jmp_redirect", {mem_en, mem_a, out_v}, {1'b1, 17'h100, 1'b0});
    wait_pc(17'h100, "jmp_first");
    check("jmp_first_op", {out_op, out_len}, {8'h60, 3'd1});
    wait_pc(17'h101, "tableswitch_seen");
    check("tableswitch", {out_op, out_len, out_err}, {8'haa, 3'd1, 1'b1});

    // Reset landing while sipush is still collecting operand bytes.
    @(posedge clk); #1 jmp_v = 1'b1; jmp_a = 17'h200;
    @(posedge clk); #1 jmp_v = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("mid_arg_state", {out_v, out_op, out_pc}, {1'b0, 8'h11, 17'h200});
    @(negedge clk);
    check_reset_vals("mid_rst");
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("refetch", {mem_en, mem_a}, {1'b1, 17'h0});
    wait_pc(17'h0, "refetch_first");
    check("refetch_op", {out_op, out_len}, {8'h00, 3'd1});
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
